// File: rtl/serial_byte_rx_if.sv
// ---------------------------------------------------------------------------
// serial_byte_rx_if
//
// Write side of the 8-entry byte buffer. The receiver pushes bytes and keeps
// an occupancy count. The consumer's read strobe is copied back to the
// receiver so that the count stays accurate.
//
// Signals:
//   write     receiver -> buffer   one-cycle push strobe
//   data_out  receiver -> buffer   byte being pushed; valid while write=1
//   level     receiver -> monitor  bytes believed resident in the buffer
//   rd_seen   consumer -> receiver one-cycle pop strobe seen by the buffer
//
// Modports:
//   master  the receiver (serial_byte_rx)
//   slave   the buffer / consumer side
// ---------------------------------------------------------------------------
interface serial_byte_rx_if #(
    parameter int LVL_W = 4
) ();
    logic             write;
    logic [7:0]       data_out;
    logic [LVL_W-1:0] level;
    logic             rd_seen;

    modport master (
        output write,
        output data_out,
        output level,
        input  rd_seen
    );

    modport slave (
        input  write,
        input  data_out,
        input  level,
        output rd_seen
    );
endinterface

// File: rtl/serial_byte_rx.sv
// ---------------------------------------------------------------------------
// serial_byte_rx
//
// This block deserialises an asynchronous UART-style line into bytes. The
// frame is 8N1 with the LSB sent first. Each byte is pushed into the 8-entry
// byte buffer downstream. The block also keeps its own copy of the buffer
// occupancy so that it never writes into a full buffer.
//
// Optional feature:
//   Defining SERIAL_RX_PARITY_EN switches the frame to 8E1, which adds an
//   even-parity bit before the stop bit. It also drives parity_err. When the
//   macro is undefined, no parity logic is built and parity_err is tied to 0.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//   DEPTH         buffer entries
//   LVL_W         occupancy counter width (must hold 0..DEPTH)
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous assert / synchronous deassert, active low
//   rx_in       asynchronous serial line, idle high
//   bus         master side of serial_byte_rx_if (write, data_out, level,
//               rd_seen)
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   overrun     sticky; a good byte was dropped because the buffer was full
//   parity_err  one-cycle pulse on a parity mismatch (parity build only)
// ---------------------------------------------------------------------------
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8,
    parameter int LVL_W        = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_in,
    serial_byte_rx_if.master       bus,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [1:0]       sync_q;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             write_q;
    logic [7:0]       data_q;
    logic [LVL_W-1:0] level_q;

    logic             sample_data;
    logic             stop_tick;
    logic             accept;
    logic             drop_full;
    logic             bad_frame;

`ifdef SERIAL_RX_PARITY_EN
    logic             parity_tick;
    logic             par_bit_q;
    logic             parity_ok;
    logic             bad_parity;
    logic             parity_err_q;
`endif

    assign bus.write    = write_q;
    assign bus.data_out = data_q;
    assign bus.level    = level_q;

    // Two-flop synchroniser. It is preset to idle-high, so a reset does not
    // look like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rxs = sync_q[1];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. BREAK waits for the line to go high again, so a
    // line held low is not mistaken for a stream of start bits.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!rxs) state_next = START;
            START:  if (cnt == HALF_M1) state_next = rxs ? IDLE : DATA;
`ifdef SERIAL_RX_PARITY_EN
            DATA:   if (cnt == FULL_M1 && bit_idx == 3'd7) state_next = PARITY;
            PARITY: if (cnt == FULL_M1) state_next = STOP;
`else
            DATA:   if (cnt == FULL_M1 && bit_idx == 3'd7) state_next = STOP;
`endif
            STOP:   if (cnt == FULL_M1) state_next = rxs ? IDLE : BREAK;
            BREAK:  if (rxs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode of the sampling points and the stop-bit verdict. A bad stop
    // bit always wins over parity. A good frame is only dropped because of
    // parity or a full buffer.
    always_comb begin
        sample_data = (state == DATA) && (cnt == FULL_M1);
        stop_tick   = (state == STOP) && (cnt == FULL_M1);
        bad_frame   = stop_tick && !rxs;
`ifdef SERIAL_RX_PARITY_EN
        parity_tick = (state == PARITY) && (cnt == FULL_M1);
        parity_ok   = (par_bit_q == ^shift_q);
        bad_parity  = stop_tick && rxs && !parity_ok;
        accept      = stop_tick && rxs && parity_ok && (level_q < DEPTH_L);
        drop_full   = stop_tick && rxs && parity_ok && (level_q >= DEPTH_L);
`else
        accept      = stop_tick && rxs && (level_q < DEPTH_L);
        drop_full   = stop_tick && rxs && (level_q >= DEPTH_L);
`endif
    end

    // Bit-timing counter. It restarts on every state change and after each
    // data bit. It rests at zero while the line is idle or broken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_next != state || sample_data ||
                     state == IDLE || state == BREAK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data shift register, filled LSB first. The bit index is restarted
    // whenever the FSM is outside DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx <= '0;
            shift_q <= '0;
        end else if (state != DATA) begin
            bit_idx <= '0;
        end else if (sample_data) begin
            shift_q[bit_idx] <= rxs;
            bit_idx          <= bit_idx + 3'd1;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    // Parity bit capture, and a registered parity_err pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (parity_tick) par_bit_q <= rxs;
            parity_err_q <= bad_parity;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Registered outputs. The write pulse lands on the cycle after the
    // stop-bit sample. Because frames are at least ten bit times apart, the
    // pulse can never be two cycles wide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q   <= 1'b0;
            data_q    <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            write_q   <= accept;
            frame_err <= bad_frame;
            if (accept)    data_q  <= shift_q;
            if (drop_full) overrun <= 1'b1;
        end
    end

    // Occupancy count follows the actual write pulse and the consumer's
    // read. When both happen in the same cycle they cancel. A read at zero
    // is ignored, so the count cannot underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            case ({write_q, bus.rd_seen})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   if (level_q != '0) level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: doc/serial_byte_rx.md
Name: serial_byte_rx

Overview:
- Upstream feeder for the 8-entry byte buffer.
- Deserialises an asynchronous UART-style line (8N1, LSB first) into bytes.
- Drives the buffer's `write` and `data_in` inputs.
- Tracks buffer occupancy by watching the consumer's read strobe, so it never writes into a full buffer.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4.
- DEPTH, 8, buffer entries (3-bit address in the downstream counter).
- LVL_W, 4, width of the occupancy counter; must hold 0..DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset_n  input  1  asynchronous reset, active low.
- rx_in  input  1  serial line; asynchronous; idle high.
- rd_seen  input  1  copy of the read request the consumer sends to the buffer; high for one cycle = one byte removed.
- write  output  1  one-cycle write pulse to the buffer.
- data_out  output  8  received byte; valid while `write`=1, held until the next byte.
- level  output  LVL_W  bytes believed resident in the buffer.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a good byte was dropped because level==DEPTH.
- parity_err  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Clock and reset: single clock `clk`. `reset_n` is asynchronous assert, synchronous deassert, active low.
- Reset values:
  - write=0, data_out=8'h00, level=0, frame_err=0, overrun=0, parity_err=0.
  - FSM in IDLE.
  - Synchroniser flops preset to 1.
- Input synchronisation: `rx_in` passes through 2 flops. "rxs" below means the synchroniser output; all decisions use rxs.
- Bit-timing counter:
  - Width ceil(log2(CLKS_PER_BIT)).
  - Cleared on every state entry.
  - Bit index 0..7.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxs==0 -> START; call that cycle T0.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rxs.
    - rxs==0 -> DATA, counter cleared.
    - rxs==1 -> IDLE (glitch rejected, no flags).
  - DATA:
    - Every CLKS_PER_BIT cycles, sample rxs into shift[bit_idx], LSB first.
    - After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs==1 and level<DEPTH: next cycle write=1, data_out=shift, level+1; -> IDLE.
    - rxs==1 and level==DEPTH: byte dropped, write stays 0, overrun<=1; -> IDLE.
    - rxs==0: frame_err=1 for one cycle, no write; -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. A held-low line never re-triggers START.
- Latency:
  - Stop-bit sample at T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - `write` pulse on the following cycle.
  - Earliest next START detection is the cycle after the STOP sample.
- Level counter:
  - +1 on write.
  - -1 on rd_seen when level>0.
  - Simultaneous write and rd_seen: unchanged.
  - rd_seen with level==0: ignored; no underflow.
  - Never exceeds DEPTH.
- `write` is never high for two consecutive cycles. The downstream logic block edge-detects it; a one-cycle pulse is one push.
- `overrun` clears only on reset.
- Reset mid-frame: everything returns to reset values immediately. The partial byte is discarded and level returns to 0; downstream is reset by the same `reset_n`.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit is sampled one CLKS_PER_BIT after bit 7, then STOP as above.
  - Parity mismatch with a good stop bit: parity_err=1 for one cycle, byte dropped, no write, no level change, -> IDLE.
  - A bad stop bit still reports frame_err only.
  - Stop-bit sample and write move 1*CLKS_PER_BIT later.
- Not defined:
  - 8N1 framing as above.
  - parity_err tied to 0.
  - No parity logic synthesised.

Test Plan (CLKS_PER_BIT=16):
- Reset, then send 8'hA5 8N1 starting at T0 -> one write pulse at T0+153, data_out=8'hA5, level=1, no flags.
- 0-cycle-wide... rather: a 5-cycle low glitch on rx_in -> START rejected mid-bit, FSM returns to IDLE, no write, no flags.
- Send 8'h3C with stop bit forced 0, line held low 40 cycles -> frame_err pulse, no write, FSM waits in BREAK, then the next valid byte 8'h01 is received correctly.
- Send 9 bytes 8'h00..8'h08 with rd_seen never asserted -> 8 writes, level=8, 9th byte dropped, overrun=1 and stays 1.
- Pulse rd_seen in the same cycle as a write at level=5 -> level stays 5. Pulse rd_seen at level=0 -> level stays 0.
- SERIAL_RX_PARITY_EN defined, send 8'h07 with parity bit 0 (odd count, so wrong) -> parity_err pulse, no write. The same byte with parity bit 1 -> write, data_out=8'h07.
